// File: rtl/main.sv
// 8-point radix-2 decimation-in-time DFT on signed Q8.8 complex samples.
// Latency: 4 rising edges from sampling a0..a7 to b0..b7; one frame per clock.
// Backpressure: none; the pipeline always advances and has no handshake.
//
// Ports:
//   clk      - single clock, all state updates on its rising edge
//   rst_n    - asynchronous active-low reset, clears every pipeline register
//   a0..a7   - time samples x[0]..x[7], [31:16] real, [15:0] imaginary, Q8.8
//   b0..b7   - spectrum X[0]..X[7], same packing, registered outputs
//
// Dataflow:
//   in_r  : inputs captured in bit-reversed order (0,4,2,6,1,5,3,7)
//   s1_r  : 2-point butterflies, all twiddles W0
//   s2_r  : 4-point butterflies, twiddles W0/W2
//   s3_r  : 8-point butterflies, twiddles W0..W3, already in natural order
//
// All butterfly arithmetic is 16-bit two's complement with wrap-around; no
// scaling is applied at any stage, so a full-scale DC input wraps in X[0].

module main (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a0,
    input  logic [31:0] a1,
    input  logic [31:0] a2,
    input  logic [31:0] a3,
    input  logic [31:0] a4,
    input  logic [31:0] a5,
    input  logic [31:0] a6,
    input  logic [31:0] a7,
    output logic [31:0] b0,
    output logic [31:0] b1,
    output logic [31:0] b2,
    output logic [31:0] b3,
    output logic [31:0] b4,
    output logic [31:0] b5,
    output logic [31:0] b6,
    output logic [31:0] b7
);

    // Complex Q8.8 sample; packing matches the port format (real in the top half).
    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } cplx_t;

    // ------------------------------------------------------------------
    // Arithmetic helpers
    // ------------------------------------------------------------------

    function automatic cplx_t c_add(input cplx_t x, input cplx_t y);
        cplx_t r;
        r.re = x.re + y.re;
        r.im = x.im + y.im;
        return r;
    endfunction

    function automatic cplx_t c_sub(input cplx_t x, input cplx_t y);
        cplx_t r;
        r.re = x.re - y.re;
        r.im = x.im - y.im;
        return r;
    endfunction

    // Multiply by W8^k. Products are formed at 32-bit precision; bits [23:8]
    // are exactly the low 16 bits of an arithmetic shift right by 8, i.e.
    // truncation toward -inf. W0 = 256 makes that slice equal to the input,
    // so k = 0 is an exact pass-through.
    function automatic cplx_t c_mul(input cplx_t x, input logic [1:0] k);
        logic signed [31:0] xr;
        logic signed [31:0] xi;
        logic signed [31:0] wr;
        logic signed [31:0] wi;
        logic signed [31:0] pr;
        logic signed [31:0] pi;
        cplx_t              r;
        xr = {{16{x.re[15]}}, x.re};
        xi = {{16{x.im[15]}}, x.im};
        case (k)
            2'd0: begin wr =  32'sd256; wi =  32'sd0;   end
            2'd1: begin wr =  32'sd181; wi = -32'sd181; end
            2'd2: begin wr =  32'sd0;   wi = -32'sd256; end
            default: begin wr = -32'sd181; wi = -32'sd181; end
        endcase
        pr   = xr * wr - xi * wi;
        pi   = xr * wi + xi * wr;
        r.re = pr[23:8];
        r.im = pi[23:8];
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------

    cplx_t [7:0] in_r;
    cplx_t [7:0] s1_r;
    cplx_t [7:0] s2_r;
    cplx_t [7:0] s3_r;

    cplx_t [7:0] s1_d;
    cplx_t [7:0] s2_d;
    cplx_t [7:0] s3_d;

    // Stage 0: capture the frame already in bit-reversed order so the later
    // stages only ever pair neighbouring slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_r <= '0;
        end else begin
            in_r[0] <= a0;
            in_r[1] <= a4;
            in_r[2] <= a2;
            in_r[3] <= a6;
            in_r[4] <= a1;
            in_r[5] <= a5;
            in_r[6] <= a3;
            in_r[7] <= a7;
        end
    end

    // Stage 1: four 2-point butterflies; the twiddle is W0, so no multiply.
    always_comb begin
        s1_d = '0;
        for (int i = 0; i < 4; i++) begin
            s1_d[2*i]   = c_add(in_r[2*i], in_r[2*i+1]);
            s1_d[2*i+1] = c_sub(in_r[2*i], in_r[2*i+1]);
        end
    end

    // Stage 2: two 4-point groups (slots 0-3 and 4-7). Within a group, slot j
    // pairs with slot j+2 using twiddle W0 for j = 0 and W2 for j = 1.
    always_comb begin
        cplx_t t;
        t    = '0;
        s2_d = '0;
        for (int g = 0; g < 8; g += 4) begin
            for (int j = 0; j < 2; j++) begin
                t             = c_mul(s1_r[g+j+2], 2'(2 * j));
                s2_d[g+j]     = c_add(s1_r[g+j], t);
                s2_d[g+j+2]   = c_sub(s1_r[g+j], t);
            end
        end
    end

    // Stage 3: slot j pairs with slot j+4 using twiddle Wj. The result lands
    // in natural order: X[j] in slot j, X[j+4] in slot j+4.
    always_comb begin
        cplx_t t;
        t    = '0;
        s3_d = '0;
        for (int j = 0; j < 4; j++) begin
            t         = c_mul(s2_r[j+4], 2'(j));
            s3_d[j]   = c_add(s2_r[j], t);
            s3_d[j+4] = c_sub(s2_r[j], t);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= '0;
            s2_r <= '0;
            s3_r <= '0;
        end else begin
            s1_r <= s1_d;
            s2_r <= s2_d;
            s3_r <= s3_d;
        end
    end

    // Outputs come straight from the last register stage.
    assign b0 = s3_r[0];
    assign b1 = s3_r[1];
    assign b2 = s3_r[2];
    assign b3 = s3_r[3];
    assign b4 = s3_r[4];
    assign b5 = s3_r[5];
    assign b6 = s3_r[6];
    assign b7 = s3_r[7];

endmodule

// File: tb/tb_main.sv
// Directed-vector bench for the 8-point DFT pipeline: known frames with
// hand-computed spectra, latency, streaming, and asynchronous reset behaviour.
module tb_main;

    logic        clk;
    logic        rst_n;
    logic [31:0] a [8];
    logic [31:0] b [8];

    int n_vec = 0;
    int n_err = 0;

    // Input frames
    logic [31:0] f_zero  [8] = '{default: 32'h0000_0000};
    logic [31:0] f_imp   [8] = '{32'h0100_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] f_dc    [8] = '{default: 32'h0100_0000};
    logic [31:0] f_shift [8] = '{32'h0, 32'h0100_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] f_ovf   [8] = '{default: 32'h7F00_0000};

    // Expected spectra
    logic [31:0] e_zero  [8] = '{default: 32'h0000_0000};
    logic [31:0] e_imp   [8] = '{default: 32'h0100_0000};
    logic [31:0] e_dc    [8] = '{32'h0800_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] e_shift [8] = '{32'h0100_0000, 32'h00B5_FF4B, 32'h0000_FF00, 32'hFF4B_FF4B,
                                 32'hFF00_0000, 32'hFF4B_00B5, 32'h0000_0100, 32'h00B5_00B5};
    logic [31:0] e_ovf   [8] = '{32'hF800_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

    main dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a0    (a[0]), .a1 (a[1]), .a2 (a[2]), .a3 (a[3]),
        .a4    (a[4]), .a5 (a[5]), .a6 (a[6]), .a7 (a[7]),
        .b0    (b[0]), .b1 (b[1]), .b2 (b[2]), .b3 (b[3]),
        .b4    (b[4]), .b5 (b[5]), .b6 (b[6]), .b7 (b[7])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input logic [31:0] f [8]);
        for (int i = 0; i < 8; i++) a[i] = f[i];
    endtask

    // Present a frame, let it travel the full pipeline, land #1 after edge 4.
    task automatic run_frame(input logic [31:0] f [8]);
        drive(f);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Reset asserted at time 0 with live data: outputs must read 0 before any edge.
        drive(f_dc);
        #1;
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (b[i] !== 32'h0) begin
                n_err++;
                $display("FAIL reset_async b%0d: got %h expected %h", i, b[i], 32'h0);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (b[i] !== 32'h0) begin
                n_err++;
                $display("FAIL reset_held b%0d: got %h expected %h", i, b[i], 32'h0);
            end
        end
        // Release with zero inputs: the zero-filled stages must emit 0, not X.
        drive(f_zero);
        rst_n = 1'b1;
        for (int e = 0; e < 4; e++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 8; i++) begin
                n_vec++;
                if (b[i] !== 32'h0) begin
                    n_err++;
                    $display("FAIL reset_fill e%0d b%0d: got %h expected %h", e, i, b[i], 32'h0);
                end
            end
        end
    endtask

    task automatic test_impulse();
        // Pipeline holds zeros; the impulse must appear on the 4th edge, not the 3rd.
        drive(f_imp);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (b[i] !== 32'h0) begin
                n_err++;
                $display("FAIL impulse_early b%0d: got %h expected %h", i, b[i], 32'h0);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (b[i] !== e_imp[i]) begin
                n_err++;
                $display("FAIL impulse b%0d: got %h expected %h", i, b[i], e_imp[i]);
            end
        end
    endtask

    task automatic test_dc();
        run_frame(f_dc);
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (b[i] !== e_dc[i]) begin
                n_err++;
                $display("FAIL dc b%0d: got %h expected %h", i, b[i], e_dc[i]);
            end
        end
    endtask

    task automatic test_shifted_impulse();
        run_frame(f_shift);
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (b[i] !== e_shift[i]) begin
                n_err++;
                $display("FAIL shifted b%0d: got %h expected %h", i, b[i], e_shift[i]);
            end
        end
    endtask

    task automatic test_overflow_wrap();
        run_frame(f_ovf);
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (b[i] !== e_ovf[i]) begin
                n_err++;
                $display("FAIL overflow b%0d: got %h expected %h", i, b[i], e_ovf[i]);
            end
        end
    endtask

    task automatic test_sampling();
        // Inputs wiggle between edges; only the value present at the edge counts.
        drive(f_dc);
        #3;
        drive(f_imp);
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (b[i] !== e_imp[i]) begin
                n_err++;
                $display("FAIL sampling b%0d: got %h expected %h", i, b[i], e_imp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_frame(f_zero);
        drive(f_imp);
        @(posedge clk); #1;
        drive(f_dc);
        @(posedge clk); #1;
        drive(f_zero);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (b[i] !== e_zero[i]) begin
                n_err++;
                $display("FAIL stream_pre b%0d: got %h expected %h", i, b[i], e_zero[i]);
            end
        end
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (b[i] !== e_imp[i]) begin
                n_err++;
                $display("FAIL stream_imp b%0d: got %h expected %h", i, b[i], e_imp[i]);
            end
        end
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (b[i] !== e_dc[i]) begin
                n_err++;
                $display("FAIL stream_dc b%0d: got %h expected %h", i, b[i], e_dc[i]);
            end
        end
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (b[i] !== e_zero[i]) begin
                n_err++;
                $display("FAIL stream_zero b%0d: got %h expected %h", i, b[i], e_zero[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        drive(f_dc);
        repeat (5) @(posedge clk);
        #1;
        n_vec++;
        if (b[0] !== 32'h0800_0000) begin
            n_err++;
            $display("FAIL midreset_pre b0: got %h expected %h", b[0], 32'h0800_0000);
        end
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (b[i] !== 32'h0) begin
                n_err++;
                $display("FAIL midreset_async b%0d: got %h expected %h", i, b[i], 32'h0);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (b[i] !== 32'h0) begin
                n_err++;
                $display("FAIL midreset_held b%0d: got %h expected %h", i, b[i], 32'h0);
            end
        end
    endtask

    task automatic test_post_reset_fill();
        // Released mid-cycle; the DC frames that were in flight must not reappear.
        rst_n = 1'b1;
        drive(f_imp);
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 8; i++) begin
                n_vec++;
                if (b[i] !== 32'h0) begin
                    n_err++;
                    $display("FAIL postreset e%0d b%0d: got %h expected %h", e, i, b[i], 32'h0);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (b[i] !== e_imp[i]) begin
                n_err++;
                $display("FAIL postreset_imp b%0d: got %h expected %h", i, b[i], e_imp[i]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(f_zero);
        test_reset();
        test_impulse();
        test_dc();
        test_shifted_impulse();
        test_overflow_wrap();
        test_sampling();
        test_back_to_back();
        test_mid_reset();
        test_post_reset_fill();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/main.md
MAIN -- requirements
Module: main

Interface
REQ-001 The interface SHALL use no parameters; data format is fixed at signed Q8.8 per component, 16 bits each.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low; SHALL be declared immediately after clk.
REQ-004 a0..a7  input  32 each  complex time samples x[0]..x[7] in natural order: [31:16] = real, [15:0] = imaginary, signed Q8.8, so 0x0100 = 1.0.
REQ-005 b0..b7  output  32 each  complex spectrum X[0]..X[7] in natural order, same packing and format as the inputs.

Function
REQ-006 The block SHALL compute an 8-point DFT, X[k] = sum over n of x[n]·W8^(nk), with W8 = e^(-j2π/8); no 1/N scaling is applied.
REQ-007 The implementation SHALL use radix-2 decimation-in-time: bit-reversed input ordering (0,4,2,6,1,5,3,7) and three butterfly stages.
REQ-008 Twiddle constants SHALL be Q8.8 values: W0 = (256, 0), W1 = (181, -181), W2 = (0, -256), W3 = (-181, -181).
REQ-009 Complex multiply rule:
- real = ar·wr − ai·wi, imag = ar·wi + ai·wr, each formed at 32-bit signed full precision.
- Each result SHALL then be arithmetic-shifted right by 8 (truncation toward −inf) and its low 16 bits kept.
- Multiplication by W0 SHALL pass data unchanged.
REQ-010 Butterfly add/subtract SHALL be 16-bit two's-complement with wrap-around on overflow; there is no saturation and no guard bits.
REQ-011 Pipeline structure, four register stages:
- input register;
- stage-1 butterfly register;
- stage-2 butterfly register;
- stage-3 butterfly register, which drives b0..b7 directly.
REQ-012 Latency SHALL be exactly 4 rising edges from sampling a0..a7 to the corresponding b0..b7.
REQ-013 Throughput SHALL be one new 8-sample frame per clock; there is no handshake and no valid signal.
REQ-014 Consecutive frames SHALL NOT interact.
REQ-015 Inputs SHALL be sampled only at rising edges; changes between edges have no effect.
REQ-016 Outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-017 While rst_n = 0, all pipeline registers SHALL clear to 0 asynchronously, so every b0..b7 = 0x00000000 immediately, without waiting for a clock edge.
REQ-018 Reset mid-operation SHALL discard all in-flight frames.
REQ-019 After rst_n rises:
- outputs SHALL stay 0 until the first post-reset sampled frame emerges 4 edges later;
- the zero-filled stages SHALL produce 0, never X.
REQ-020 Outputs SHALL be 0 before the first frame arrives; uninitialized inputs (X) SHALL propagate only through the data path.

Verification
REQ-021 Impulse: a0 = 0x01000000, a1..a7 = 0 -> after 4 edges, b0..b7 all = 0x01000000.
REQ-022 DC: a0..a7 = 0x01000000 -> after 4 edges:
- b0 = 0x08000000;
- b1..b7 = 0x00000000.
REQ-023 Shifted impulse: a1 = 0x01000000, others 0 -> after 4 edges:
- b0 = 0x01000000, b1 = 0x00B5FF4B, b2 = 0x0000FF00, b3 = 0xFF4BFF4B;
- b4 = 0xFF000000, b5 = 0xFF4B00B5, b6 = 0x00000100, b7 = 0x00B500B5.
REQ-024 Overflow wrap: a0..a7 = 0x7F000000 -> after 4 edges:
- b0 = 0xF8000000;
- b1..b7 = 0x00000000.
REQ-025 Streaming: impulse, then DC, then zero frames on consecutive edges -> the matching results (REQ-021, REQ-022, then all 0) appear on consecutive edges 4 cycles later, with no cross-talk.
REQ-026 Mid-stream reset: assert rst_n = 0 between edges during streaming -> b0..b7 = 0 immediately.
REQ-027 Post-reset fill: release rst_n, then apply the impulse frame -> outputs stay 0 until the 4th edge after the impulse is sampled, then all = 0x01000000.
